// File: rtl/la_control_mux.sv
// la_control_mux: Wishbone-programmable logic-analyzer router with shadow/commit selects and snapshots.
//   wb_clk_i/wb_rst_i         : clock, synchronous active-high reset
//   wbs_*                     : Wishbone slave (single-cycle ack, never stalls)
//   designs_la_data_out/oenb  : per-team LA data and active-low enables, team t at slice t-1
//   la_data_out/la_oenb       : routed LA outputs, driven only from committed selects
module la_control_mux #(
    parameter int          NUM_TEAMS = 12,
    parameter int          LA_WIDTH  = 128,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_we_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic [31:0]                   wbs_dat_i,
    input  logic [31:0]                   wbs_adr_i,
    output logic                          wbs_ack_o,
    output logic [31:0]                   wbs_dat_o,
    input  logic [NUM_TEAMS*LA_WIDTH-1:0] designs_la_data_out,
    input  logic [NUM_TEAMS*LA_WIDTH-1:0] designs_la_oenb,
    output logic [LA_WIDTH-1:0]           la_data_out,
    output logic [LA_WIDTH-1:0]           la_oenb
);
    localparam int NSEL  = LA_WIDTH / 8;
    localparam int NSNAP = (LA_WIDTH + 31) / 32;
    logic [LA_WIDTH*4-1:0] r_shadow;
    logic [LA_WIDTH*4-1:0] r_active;
    logic [LA_WIDTH-1:0]   r_snap;
    logic                  r_pending;
    logic [7:0]            r_snap_cnt;
    logic                  r_ack;
    logic [31:0]           r_dat;
    logic                  w_go;
    logic                  w_wr;
    logic [9:0]            w_off;
    logic [31:0]           w_rdata;
    logic [NSNAP*32-1:0]   w_snap_pad;
    logic                  w_unused;

    // Only the 10-bit offset is decoded; upper address bits and the base are informational.
    assign w_off     = wbs_adr_i[9:0];
    assign w_go      = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_wr      = w_go & wbs_we_i;
    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign w_unused  = ^{wbs_adr_i[31:10], wbs_adr_i[1:0], BASE_ADDR};

    always_comb begin
        w_snap_pad                 = '0;
        w_snap_pad[LA_WIDTH-1:0]   = r_snap;
    end

    always_comb begin
        w_rdata = '0;
        if (w_off[9:8] == 2'b00) begin
            for (int i = 0; i < NSEL; i++)
                if (w_off[7:2] == 6'(i)) w_rdata = r_shadow[i*32 +: 32];
        end else if (w_off == 10'h104) begin
            w_rdata = {16'h0, r_snap_cnt, 7'h0, r_pending};
        end else if (w_off[9:8] == 2'b10) begin
            for (int j = 0; j < NSNAP; j++)
                if (w_off[7:2] == 6'(j)) w_rdata = w_snap_pad[j*32 +: 32];
        end
    end

    // Out-of-range selects (0 or above NUM_TEAMS) fall through to the idle defaults.
    always_comb begin
        la_data_out = '0;
        la_oenb     = '1;
        for (int b = 0; b < LA_WIDTH; b++)
            for (int t = 1; t <= NUM_TEAMS; t++)
                if (r_active[b*4 +: 4] == 4'(t)) begin
                    la_data_out[b] = designs_la_data_out[(t-1)*LA_WIDTH + b];
                    la_oenb[b]     = designs_la_oenb[(t-1)*LA_WIDTH + b];
                end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_shadow   <= '0;
            r_active   <= '0;
            r_snap     <= '0;
            r_pending  <= 1'b0;
            r_snap_cnt <= '0;
            r_ack      <= 1'b0;
            r_dat      <= '0;
        end else begin
            r_ack <= w_go;
            r_dat <= (w_go & ~wbs_we_i) ? w_rdata : '0;
            if (w_wr && w_off[9:8] == 2'b00) begin
                for (int i = 0; i < NSEL; i++)
                    if (w_off[7:2] == 6'(i)) begin
                        r_pending <= 1'b1;
                        for (int k = 0; k < 4; k++)
                            if (wbs_sel_i[k]) r_shadow[i*32 + k*8 +: 8] <= wbs_dat_i[k*8 +: 8];
                    end
            end
            if (w_wr && w_off == 10'h100) begin
                if (wbs_dat_i[0]) begin
                    r_active  <= r_shadow;
                    r_pending <= 1'b0;
                end
                // la_data_out still reflects the pre-commit selects on this edge.
                if (wbs_dat_i[1]) begin
                    r_snap     <= la_data_out;
                    r_snap_cnt <= r_snap_cnt + {7'h0, r_snap_cnt != 8'hFF};
                end
            end
        end
    end
endmodule

// File: tb/tb_la_control_mux.sv
// tb_la_control_mux: scoreboard bench for la_control_mux with a per-bit behavioural model.
module tb_la_control_mux;
    localparam int NT = 12;
    localparam int LW = 128;
    localparam logic [31:0] BASE = 32'h3000_0000;

    typedef struct {
        bit          chk;
        logic [31:0] d;
        string       nm;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              stb = 1'b0;
    logic              cyc = 1'b0;
    logic              we  = 1'b0;
    logic [3:0]        sel = 4'h0;
    logic [31:0]       dat = '0;
    logic [31:0]       adr = '0;
    logic              ack;
    logic [31:0]       rdat;
    logic [NT*LW-1:0]  tdata = '0;
    logic [NT*LW-1:0]  toenb = '0;
    logic [LW-1:0]     la_d;
    logic [LW-1:0]     la_o;

    exp_t        q[$];
    exp_t        m_e;
    int          checks = 0;
    int          errors = 0;
    int          sh[LW];
    int          ac[LW];
    logic [LW-1:0] m_snap;
    int          cnt;
    bit          pend;

    always #5 clk = ~clk;

    la_control_mux #(.NUM_TEAMS(NT), .LA_WIDTH(LW), .BASE_ADDR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .designs_la_data_out(tdata), .designs_la_oenb(toenb), .la_data_out(la_d), .la_oenb(la_o)
    );

    task automatic cmp(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=1 required=0");
            end else begin
                m_e = q.pop_front();
                if (m_e.chk) cmp(m_e.nm, LW'(rdat), LW'(m_e.d));
            end
        end else begin
            cmp("dat_idle", LW'(rdat), '0);
        end
    end

    function automatic logic [LW-1:0] exp_data();
        logic [LW-1:0] r = '0;
        for (int b = 0; b < LW; b++)
            if (ac[b] >= 1 && ac[b] <= NT) r[b] = tdata[(ac[b]-1)*LW + b];
        return r;
    endfunction

    function automatic logic [LW-1:0] exp_oenb();
        logic [LW-1:0] r = '1;
        for (int b = 0; b < LW; b++)
            if (ac[b] >= 1 && ac[b] <= NT) r[b] = toenb[(ac[b]-1)*LW + b];
        return r;
    endfunction

    function automatic logic [31:0] sel_word(input int i);
        logic [31:0] w = '0;
        for (int n = 0; n < 8; n++) w[4*n +: 4] = 4'(sh[8*i + n]);
        return w;
    endfunction

    function automatic logic [31:0] exp_read(input int off);
        logic [31:0] r = '0;
        if (off < 'h100) begin
            if (off / 4 < LW / 8) r = sel_word(off / 4);
        end else if (off == 'h104) begin
            r = {16'h0, 8'(cnt), 7'h0, pend};
        end else if (off >= 'h200 && off < 'h300) begin
            for (int k = 0; k < LW / 32; k++)
                if (k == (off - 'h200) / 4) r = m_snap[k*32 +: 32];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < LW; b++) begin
            sh[b] = 0;
            ac[b] = 0;
        end
        m_snap = '0;
        cnt    = 0;
        pend   = 0;
    endtask

    task automatic wb(input bit w, input int off, input logic [31:0] d, input logic [3:0] s, input string nm);
        exp_t e;
        int n;
        e.chk = !w;
        e.d   = w ? 32'h0 : exp_read(off);
        e.nm  = nm;
        q.push_back(e);
        @(negedge clk);
        adr = BASE | 32'(off);
        we  = w;
        dat = d;
        sel = s;
        stb = 1'b1;
        cyc = 1'b1;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 4);
        if (!ack) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout_%s actual=0 required=1", nm);
        end
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
        if (w && ack) begin
            if (off < 'h100 && off / 4 < LW / 8) begin
                for (int k = 0; k < 8; k++)
                    if (s[k/2]) sh[8*(off/4) + k] = int'(d[4*k +: 4]);
                pend = 1;
            end
            if (off == 'h100) begin
                if (d[1]) begin
                    m_snap = exp_data();
                    if (cnt < 255) cnt++;
                end
                if (d[0]) begin
                    ac   = sh;
                    pend = 0;
                end
            end
        end
    endtask

    task automatic check_outs(input string nm);
        @(negedge clk);
        cmp({nm, "_data"}, la_d, exp_data());
        cmp({nm, "_oenb"}, la_o, exp_oenb());
    endtask

    task automatic rand_teams();
        for (int w = 0; w < NT*LW/32; w++) begin
            tdata[w*32 +: 32] = $urandom;
            toenb[w*32 +: 32] = $urandom;
        end
    endtask

    initial begin
        int r;
        int off;
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rand_teams();
        @(negedge clk);
        cmp("rst_oenb", la_o, '1);
        cmp("rst_data", la_d, '0);
        cmp("rst_ack", LW'(ack), '0);
        wb(0, 'h104, 0, 4'hF, "rst_status");

        wb(1, 'h000, 32'h21, 4'hF, "w_sel0");
        wb(0, 'h000, 0, 4'hF, "rd_sel0");
        wb(0, 'h104, 0, 4'hF, "status_pend");
        check_outs("precommit");
        wb(1, 'h100, 32'h1, 4'hF, "commit0");
        check_outs("commit0");
        wb(0, 'h104, 0, 4'hF, "status_clear");

        wb(1, 'h004, 32'hFFFF_FFFF, 4'b0010, "w_sel1_byte");
        wb(0, 'h004, 0, 4'hF, "rd_sel1");
        wb(1, 'h100, 32'h1, 4'hF, "commit1");
        check_outs("sel15");

        tdata[31:0] = 32'hA5A5_A5A5;
        for (int i = 0; i < LW / 8; i++) wb(1, 4*i, 32'h1111_1111, 4'hF, "w_all1");
        wb(1, 'h100, 32'h1, 4'hF, "commit_all1");
        check_outs("all1");
        wb(1, 'h100, 32'h2, 4'hF, "snap1");
        for (int j = 0; j < 5; j++) wb(0, 'h200 + 4*j, 0, 4'hF, "rd_snap");
        wb(0, 'h104, 0, 4'hF, "status_snap1");
        for (int i = 0; i < 300; i++) wb(1, 'h100, 32'h2, 4'hF, "snap_many");
        wb(0, 'h104, 0, 4'hF, "status_sat");

        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 5);
            if (r <= 1) begin
                wb(1, 4*$urandom_range(0, LW/8 - 1), $urandom, 4'($urandom), "rnd_wsel");
            end else if (r == 2) begin
                wb(1, 'h100, 32'($urandom_range(0, 3)), 4'hF, "rnd_ctrl");
            end else if (r == 3) begin
                case ($urandom_range(0, 4))
                    0: off = 4*$urandom_range(0, LW/8 - 1);
                    1: off = 'h104;
                    2: off = 'h200 + 4*$urandom_range(0, 5);
                    3: off = 'h040 + 4*$urandom_range(0, 47);
                    default: off = 'h100;
                endcase
                wb(0, off, 0, 4'hF, "rnd_rd");
            end else if (r == 4) begin
                wb(1, 'h3F0, $urandom, 4'hF, "rnd_unmapped_w");
            end else begin
                rand_teams();
            end
            check_outs("rnd");
        end

        for (int i = 0; i < 3; i++) q.push_back('{chk: 1'b1, d: {16'h0, 8'(cnt), 7'h0, pend}, nm: "hold_rd"});
        @(negedge clk);
        adr = BASE | 32'h104;
        we  = 1'b0;
        stb = 1'b1;
        cyc = 1'b1;
        #1 cmp("ack_pat0", LW'(ack), '0);
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            cmp("ack_pat", LW'(ack), LW'(i % 2));
        end
        stb = 1'b0;
        cyc = 1'b0;
        wb(0, 'h3F0, 0, 4'hF, "rd_unmapped");

        for (int i = 0; i < LW / 8; i++) wb(1, 4*i, 32'h3333_3333, 4'hF, "w_all3");
        wb(1, 'h100, 32'h1, 4'hF, "commit_all3");
        check_outs("all3");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        cmp("rst2_oenb", la_o, '1);
        cmp("rst2_data", la_d, '0);
        stb = 1'b1;
        cyc = 1'b1;
        we  = 1'b1;
        adr = BASE;
        dat = 32'hFF;
        sel = 4'hF;
        @(negedge clk);
        cmp("rst_pending_ack", LW'(ack), '0);
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
        rst = 1'b0;
        wb(0, 'h000, 0, 4'hF, "rd_sel0_after_rst");
        wb(0, 'h104, 0, 4'hF, "status_after_rst");
        repeat (3) @(negedge clk);
        cmp("queue_empty", LW'(q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
